// File: rtl/spi_master_multi_if.sv
// Fabric-side handshake bundle for spi_master_multi.
// The "master" modport is the fabric logic that requests frames; the
// "slave" modport is the SPI master block that serves them.
// Optional feature macro: SPI_MASTER_MULTI_LSB_FIRST_EN adds lsb_first.
interface spi_master_multi_if #(
    parameter int FRAME_LEN = 16
);
    logic                 start;
    logic [FRAME_LEN-1:0] tx_data;
    logic                 cpol;
    logic                 cpha;
    logic [2:0]           cs_sel;
`ifdef SPI_MASTER_MULTI_LSB_FIRST_EN
    logic                 lsb_first;
`endif
    logic                 busy;
    logic                 done;
    logic [FRAME_LEN-1:0] rx_data;

`ifdef SPI_MASTER_MULTI_LSB_FIRST_EN
    modport master (output start, tx_data, cpol, cpha, cs_sel, lsb_first,
                    input  busy, done, rx_data);
    modport slave  (input  start, tx_data, cpol, cpha, cs_sel, lsb_first,
                    output busy, done, rx_data);
`else
    modport master (output start, tx_data, cpol, cpha, cs_sel,
                    input  busy, done, rx_data);
    modport slave  (input  start, tx_data, cpol, cpha, cs_sel,
                    output busy, done, rx_data);
`endif
endinterface

// File: rtl/spi_master_multi.sv
// Parameterised SPI master: all four SPI modes, CS_COUNT active-low selects,
// programmable half-bit time and inter-frame gap, start/busy/done handshake.
// Frame sequence: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE.
// Optional feature macro: SPI_MASTER_MULTI_LSB_FIRST_EN (adds lsb_first to
// the handshake bundle; without it every transfer is MSB first).
// LSB-first frames are handled by bit-reversing the word on the way in and
// out, so the shifter itself only ever works MSB first.
module spi_master_multi #(
    parameter int FRAME_LEN     = 16,
    parameter int HALF_BIT      = 25,
    parameter int CS_COUNT      = 1,
    parameter int GAP_HALF_BITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    spi_master_multi_if.slave   bus,
    output logic [CS_COUNT-1:0] ssel_n_o,
    output logic                sclk_o,
    output logic                mosi_o,
    input  logic                miso_i
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;

    localparam int CW       = $clog2(HALF_BIT);
    localparam int EDGE_MAX = (2 * FRAME_LEN > GAP_HALF_BITS) ? 2 * FRAME_LEN : GAP_HALF_BITS;
    localparam int EW       = $clog2(EDGE_MAX + 1);

    localparam logic [CW-1:0] CNT_LAST  = CW'(HALF_BIT - 1);
    localparam logic [EW-1:0] EDGE_LAST = EW'(2 * FRAME_LEN);
    localparam logic [EW-1:0] GAP_LAST  = EW'(GAP_HALF_BITS);

    logic [2:0]           state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [EW-1:0]        edge_q, edge_d;
    logic [FRAME_LEN-1:0] tx_q, tx_d;
    logic [FRAME_LEN-1:0] rx_q, rx_d;
    logic [FRAME_LEN-1:0] rx_data_q, rx_data_d;
    logic                 cpol_q, cpol_d;
    logic                 cpha_q, cpha_d;
    logic [CS_COUNT-1:0]  ssel_q, ssel_d;
    logic                 sclk_q, sclk_d;
    logic                 mosi_q, mosi_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic                 half_end;
    logic [EW-1:0]        edge_next;
    logic                 sample_now;
    logic [FRAME_LEN-1:0] load_word;
    logic [FRAME_LEN-1:0] rx_word;

    assign half_end   = (cnt_q == CNT_LAST);
    assign edge_next  = edge_q + EW'(1);
    // Odd edges are leading; cpha=0 samples on leading, cpha=1 on trailing.
    assign sample_now = edge_next[0] ^ cpha_q;

`ifdef SPI_MASTER_MULTI_LSB_FIRST_EN
    logic lsb_q;

    function automatic logic [FRAME_LEN-1:0] reverse_bits(input logic [FRAME_LEN-1:0] v);
        logic [FRAME_LEN-1:0] r;
        for (int i = 0; i < FRAME_LEN; i++) r[i] = v[FRAME_LEN-1-i];
        return r;
    endfunction

    // Capture the bit-order choice together with the rest of the frame setup.
    always_ff @(posedge clk) begin
        if (!rst_n) lsb_q <= 1'b0;
        else if (state_q == S_IDLE && bus.start) lsb_q <= bus.lsb_first;
    end

    // Reverse the word in and out so the shifter always runs MSB first.
    always_comb begin
        load_word = bus.lsb_first ? reverse_bits(bus.tx_data) : bus.tx_data;
        rx_word   = lsb_q ? reverse_bits(rx_q) : rx_q;
    end
`else
    assign load_word = bus.tx_data;
    assign rx_word   = rx_q;
`endif

    // Next-state logic: half-bit timing, SCLK edges, shifting and handshake.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        edge_d    = edge_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        rx_data_d = rx_data_q;
        cpol_d    = cpol_q;
        cpha_d    = cpha_q;
        ssel_d    = ssel_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        if (state_q != S_IDLE) cnt_d = half_end ? '0 : cnt_q + CW'(1);

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (bus.start) begin
                    state_d = S_SETUP;
                    busy_d  = 1'b1;
                    cpol_d  = bus.cpol;
                    cpha_d  = bus.cpha;
                    sclk_d  = bus.cpol;
                    edge_d  = '0;
                    rx_d    = '0;
                    ssel_d  = '1;
                    if (int'(bus.cs_sel) < CS_COUNT) ssel_d = ~(CS_COUNT'(1) << bus.cs_sel);
                    if (bus.cpha) begin
                        mosi_d = 1'b0;
                        tx_d   = load_word;
                    end else begin
                        mosi_d = load_word[FRAME_LEN-1];
                        tx_d   = load_word << 1;
                    end
                end
            end
            S_SETUP, S_SHIFT: begin
                if (half_end) begin
                    edge_d = edge_next;
                    sclk_d = ~sclk_q;
                    if (sample_now) begin
                        rx_d = {rx_q[FRAME_LEN-2:0], miso_i};
                    end else if (edge_next != EDGE_LAST) begin
                        mosi_d = tx_q[FRAME_LEN-1];
                        tx_d   = tx_q << 1;
                    end
                    if (edge_next == EDGE_LAST) begin
                        state_d = S_HOLD;
                        sclk_d  = cpol_q;
                        mosi_d  = 1'b0;
                    end else begin
                        state_d = S_SHIFT;
                    end
                end
            end
            S_HOLD: begin
                if (half_end) begin
                    ssel_d = '1;
                    edge_d = '0;
                    if (GAP_HALF_BITS == 0) begin
                        state_d   = S_IDLE;
                        busy_d    = 1'b0;
                        done_d    = 1'b1;
                        rx_data_d = rx_word;
                    end else begin
                        state_d = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (half_end) begin
                    edge_d = edge_next;
                    if (edge_next == GAP_LAST) begin
                        state_d   = S_IDLE;
                        busy_d    = 1'b0;
                        done_d    = 1'b1;
                        rx_data_d = rx_word;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register with synchronous active-low reset; a mid-frame reset drops the frame silently.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            edge_q    <= '0;
            tx_q      <= '0;
            rx_q      <= '0;
            rx_data_q <= '0;
            cpol_q    <= 1'b0;
            cpha_q    <= 1'b0;
            ssel_q    <= '1;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            edge_q    <= edge_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            rx_data_q <= rx_data_d;
            cpol_q    <= cpol_d;
            cpha_q    <= cpha_d;
            ssel_q    <= ssel_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.rx_data = rx_data_q;
    assign ssel_n_o    = ssel_q;
    assign sclk_o      = sclk_q;
    assign mosi_o      = mosi_q;

endmodule

// File: tb/tb_spi_master_multi.sv
// Self-checking bench for spi_master_multi (FRAME_LEN=16, HALF_BIT=25,
// CS_COUNT=4, GAP_HALF_BITS=4). Expected timing, select pattern and data
// come from the frame-level rules: frame-relative cycle numbers, edge index
// k, bit index j. Build with +define+SPI_MASTER_MULTI_LSB_FIRST_EN to also
// exercise LSB-first frames.
module tb_spi_master_multi;

    localparam int F       = 16;
    localparam int HB      = 25;
    localparam int CSC     = 4;
    localparam int G       = 4;
    localparam int PERIOD  = 1 + (2 * F + 1 + G) * HB;
    localparam int SEL_END = (2 * F + 1) * HB;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [CSC-1:0] sselN;
    logic           sclk;
    logic           mosi;
    logic           miso;
    logic           misoDrv;
    logic           loopSel;

    int passCount  = 0;
    int checkCount = 0;

    spi_master_multi_if #(.FRAME_LEN(F)) bus ();

    spi_master_multi #(
        .FRAME_LEN(F), .HALF_BIT(HB), .CS_COUNT(CSC), .GAP_HALF_BITS(G)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .ssel_n_o(sselN), .sclk_o(sclk), .mosi_o(mosi), .miso_i(miso)
    );

    always #5 clk = ~clk;

    assign miso = loopSel ? mosi : misoDrv;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) passCount++;
        else $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    endtask

    function automatic bit isSample(input int k, input logic pha);
        return ((k % 2) == 1) ^ (pha == 1'b1);
    endfunction

    function automatic int bitIndex(input int k, input logic pha);
        return pha ? (k - 2) / 2 : (k - 1) / 2;
    endfunction

    // Runs one frame and checks every cycle of it against the frame rules.
    task automatic applyStimulus(input logic [F-1:0] tx, input logic pol, input logic pha,
                                 input logic [2:0] cs, input logic lsb, input bit loop,
                                 input logic [F-1:0] pat);
        int c = 1;
        int doneAt = -1;
        int k, j;
        int toggles = 0, badToggles = 0, badMosi = 0, badSel = 0, badBusy = 0, rxChanges = 0;
        logic prevSclk, prevMosi;
        logic [F-1:0] gotTx = '0;
        logic [F-1:0] prevRx;
        logic [F-1:0] expRx;
        logic [CSC-1:0] expSel;
        bit allowed;

        @(negedge clk);
        prevRx = bus.rx_data;
        prevSclk = pol;
        prevMosi = 1'b0;
        bus.start = 1'b1;
        bus.tx_data = tx;
        bus.cpol = pol;
        bus.cpha = pha;
        bus.cs_sel = cs;
`ifdef SPI_MASTER_MULTI_LSB_FIRST_EN
        bus.lsb_first = lsb;
`endif
        loopSel = loop;
        misoDrv = 1'b0;
        @(posedge clk);
        while (c <= PERIOD + 40) begin
            #1;
            bus.start = 1'b0;
            bus.tx_data = F'($urandom);
            bus.cpol = 1'($urandom);
            bus.cpha = 1'($urandom);
            bus.cs_sel = 3'($urandom);
`ifdef SPI_MASTER_MULTI_LSB_FIRST_EN
            bus.lsb_first = 1'($urandom);
`endif
            k = (c - 1) / HB + 1;
            if (k <= 2 * F && isSample(k, pha)) begin
                j = bitIndex(k, pha);
                misoDrv = lsb ? pat[j] : pat[F-1-j];
            end
            @(negedge clk);
            if (sclk !== prevSclk) begin
                toggles++;
                k = (c - 1) / HB;
                if (!((c - 1) % HB == 0 && k >= 1 && k <= 2 * F)) badToggles++;
            end
            prevSclk = sclk;
            if (mosi !== prevMosi) begin
                k = (c - 1) / HB;
                allowed = (c == 1 && !pha) ||
                          ((c - 1) % HB == 0 && k >= 1 && k <= 2 * F && (!isSample(k, pha) || k == 2 * F));
                if (!allowed) badMosi++;
            end
            prevMosi = mosi;
            if (c % HB == 0) begin
                k = c / HB;
                if (k >= 1 && k <= 2 * F && isSample(k, pha)) begin
                    j = bitIndex(k, pha);
                    gotTx[lsb ? j : F - 1 - j] = mosi;
                end
            end
            expSel = '1;
            if (c <= SEL_END && int'(cs) < CSC) expSel = ~(CSC'(1) << cs);
            if (sselN !== expSel) badSel++;
            if (bus.busy !== (c < PERIOD)) badBusy++;
            if (bus.done === 1'b1) begin
                doneAt = c;
                break;
            end
            if (bus.rx_data !== prevRx) rxChanges++;
            c++;
            @(posedge clk);
        end
        expRx = loop ? tx : pat;
        checkOutput("doneCycle", 32'(doneAt), 32'(PERIOD));
        checkOutput("rxData", 32'(bus.rx_data), 32'(expRx));
        checkOutput("mosiBits", 32'(gotTx), 32'(tx));
        checkOutput("sclkToggles", 32'(toggles), 32'(2 * F));
        checkOutput("sclkBadEdge", 32'(badToggles), 32'd0);
        checkOutput("mosiBadEdge", 32'(badMosi), 32'd0);
        checkOutput("sselPattern", 32'(badSel), 32'd0);
        checkOutput("busyPattern", 32'(badBusy), 32'd0);
        checkOutput("rxHeld", 32'(rxChanges), 32'd0);
    endtask

    // Holds start high until the third frame is accepted.
    task automatic runBackToBack();
        int cyc = 0, dones = 0, run = 0, highRun = 0;
        int d[3] = '{0, 0, 0};
        bit seenLow = 0, runDone = 0;

        @(negedge clk);
        bus.start = 1'b1;
        bus.tx_data = 16'h5A3C;
        bus.cpol = 1'b0;
        bus.cpha = 1'b0;
        bus.cs_sel = 3'd0;
`ifdef SPI_MASTER_MULTI_LSB_FIRST_EN
        bus.lsb_first = 1'b0;
`endif
        loopSel = 1'b1;
        while (cyc < 3 * PERIOD + 1000) begin
            @(posedge clk);
            #1;
            if (dones >= 2) bus.start = 1'b0;
            @(negedge clk);
            cyc++;
            if (bus.done === 1'b1) begin
                if (dones < 3) d[dones] = cyc;
                dones++;
            end
            if (sselN[0] === 1'b0) begin
                if (seenLow && run > 0 && !runDone) begin
                    highRun = run;
                    runDone = 1;
                end
                seenLow = 1;
                run = 0;
            end else if (seenLow) begin
                run++;
            end
        end
        checkOutput("b2bDoneCount", 32'(dones), 32'd3);
        checkOutput("b2bFirstDone", 32'(d[0]), 32'(PERIOD));
        checkOutput("b2bSpacing1", 32'(d[1] - d[0]), 32'(PERIOD));
        checkOutput("b2bSpacing2", 32'(d[2] - d[1]), 32'(PERIOD));
        checkOutput("b2bSselHigh", 32'(highRun), 32'(G * HB + 1));
        checkOutput("b2bRxData", 32'(bus.rx_data), 32'h5A3C);
    endtask

    // Resets in cycle 300 of a frame, then confirms the frame never completes.
    task automatic runMidFrameReset();
        int doneSeen = 0, busySeen = 0;

        @(negedge clk);
        bus.start = 1'b1;
        bus.tx_data = 16'hFFFF;
        bus.cpol = 1'b1;
        bus.cpha = 1'b0;
        bus.cs_sel = 3'd1;
`ifdef SPI_MASTER_MULTI_LSB_FIRST_EN
        bus.lsb_first = 1'b0;
`endif
        loopSel = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (299) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("midRstSsel", 32'(sselN), 32'hF);
        checkOutput("midRstSclk", 32'(sclk), 32'd0);
        checkOutput("midRstBusy", 32'(bus.busy), 32'd0);
        checkOutput("midRstMosi", 32'(mosi), 32'd0);
        repeat (PERIOD + 100) begin
            @(negedge clk);
            if (bus.done === 1'b1) doneSeen++;
            if (bus.busy === 1'b1) busySeen++;
        end
        checkOutput("midRstNoDone", 32'(doneSeen), 32'd0);
        checkOutput("midRstNoBusy", 32'(busySeen), 32'd0);
        applyStimulus(16'h1234, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 16'h0000);
    endtask

    // Main sequence: reset, directed frames, handshake corners, random frames.
    initial begin
        logic [F-1:0] rTx, rPat;
        logic rPol, rPha, rLsb;
        logic [2:0] rCs;
        bit rLoop;

        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.tx_data = '0;
        bus.cpol = 1'b0;
        bus.cpha = 1'b0;
        bus.cs_sel = 3'd0;
`ifdef SPI_MASTER_MULTI_LSB_FIRST_EN
        bus.lsb_first = 1'b0;
`endif
        loopSel = 1'b0;
        misoDrv = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("resetSsel", 32'(sselN), 32'hF);
        checkOutput("resetSclk", 32'(sclk), 32'd0);
        checkOutput("resetMosi", 32'(mosi), 32'd0);
        checkOutput("resetBusy", 32'(bus.busy), 32'd0);
        checkOutput("resetDone", 32'(bus.done), 32'd0);
        checkOutput("resetRx", 32'(bus.rx_data), 32'd0);
        rst_n = 1'b1;

        applyStimulus(16'h37FF, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 16'h0000);
        applyStimulus(16'hA5C3, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 16'hFFFF);
        applyStimulus(16'h6B2D, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 16'h9C41);
        applyStimulus(16'hC0DE, 1'b1, 1'b0, 3'd5, 1'b0, 1'b1, 16'h0000);
`ifdef SPI_MASTER_MULTI_LSB_FIRST_EN
        applyStimulus(16'h0001, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 16'h0000);
        applyStimulus(16'hB00C, 1'b1, 1'b1, 3'd1, 1'b1, 1'b0, 16'h3A05);
`endif
        runBackToBack();
        runMidFrameReset();

        for (int i = 0; i < 8; i++) begin
            rTx = F'($urandom);
            rPat = F'($urandom);
            rPol = 1'($urandom);
            rPha = 1'($urandom);
            rCs = 3'($urandom_range(0, 7));
            rLoop = 1'($urandom);
`ifdef SPI_MASTER_MULTI_LSB_FIRST_EN
            rLsb = 1'($urandom);
`else
            rLsb = 1'b0;
`endif
            applyStimulus(rTx, rPol, rPha, rCs, rLsb, rLoop, rPat);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
